// File: rtl/ball_pkg.sv
// ball_pkg: screen, ball and paddle geometry shared by the collision, draw and motion blocks.
package ball_pkg;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int BALL_R   = 10;
  localparam int PAD_Y    = 700;
  localparam int PAD_H    = 10;
  localparam int PAD_W    = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, LOCKOUT = 2'd2} hit_state_t;
endpackage

// File: rtl/rect_overlap.sv
// rect_overlap: registers a sprite centre and a box origin, then flags their overlap a cycle later.
module rect_overlap #(
  parameter int R  = 10,
  parameter int Y0 = 700,
  parameter int H  = 10,
  parameter int W  = 128
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] a_x_i,
  input  logic [11:0] a_y_i,
  input  logic [11:0] b_x_i,
  output logic [11:0] a_y_q,
  output logic        overlap_q
);
  logic [11:0] ax_q, bx_q;
  logic [12:0] ay_r, ax_r, bx_e;
  logic        overlap_d;
  // 13-bit sums so a box near the right edge of the 12-bit range cannot wrap into a false hit
  always_comb begin
    ay_r      = {1'b0, a_y_q} + 13'(R);
    ax_r      = {1'b0, ax_q} + 13'(R);
    bx_e      = {1'b0, bx_q} + 13'(W - 1 + R);
    overlap_d = (ay_r >= 13'(Y0)) && (ay_r <= 13'(Y0 + H - 1)) &&
                (ax_r >= {1'b0, bx_q}) && ({1'b0, ax_q} <= bx_e);
  end
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      ax_q      <= '0;
      a_y_q     <= '0;
      bx_q      <= '0;
      overlap_q <= 1'b0;
    end else begin
      ax_q      <= a_x_i;
      a_y_q     <= a_y_i;
      bx_q      <= b_x_i;
      overlap_q <= overlap_d;
    end
  end
endmodule

// File: rtl/ball_paddle_collide.sv
// ball_paddle_collide: paddle hit flag with consume/timeout handshake, miss pulse and hit counter.
module ball_paddle_collide
  import ball_pkg::*;
#(
  parameter int HOLD_MAX = 2_000_000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  input  logic [11:0] pad_x,
  output logic        collision_det,
  output logic        miss,
  output logic [7:0]  hit_count
);
  localparam int HW = $clog2(HOLD_MAX + 1);
  hit_state_t  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [11:0] y_hit_q, y_hit_d, by_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        overlap_q, bot, bot_q, miss_q;
  rect_overlap #(.R(BALL_R), .Y0(PAD_Y), .H(PAD_H), .W(PAD_W)) u_ov (
    .pclk      (pclk),
    .reset     (reset),
    .a_x_i     (ball_x),
    .a_y_i     (ball_y),
    .b_x_i     (pad_x),
    .a_y_q     (by_q),
    .overlap_q (overlap_q)
  );
  assign bot = ({1'b0, by_q} + 13'(BALL_R)) >= 13'(SCREEN_H - 1);
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      y_hit_q <= '0;
      cnt_q   <= '0;
      bot_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_hit_q <= y_hit_d;
      cnt_q   <= cnt_d;
      bot_q   <= bot;
      miss_q  <= bot & ~bot_q;
    end
  end
  // the hit is considered consumed once the motion block has moved the ball off the latched row
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_hit_d = y_hit_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (overlap_q) begin
        state_d = ASSERT;
        y_hit_d = by_q;
        hold_d  = '0;
        cnt_d   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
      end
      ASSERT: if (by_q != y_hit_q || hold_q == HW'(HOLD_MAX - 1)) state_d = LOCKOUT;
              else hold_d = hold_q + HW'(1);
      LOCKOUT: state_d = overlap_q ? LOCKOUT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    collision_det = (state_q == ASSERT);
    miss          = miss_q;
    hit_count     = cnt_q;
  end
endmodule

// File: tb/tb_ball_paddle_collide.sv
// tb_ball_paddle_collide: vector table, directed corner sequences and random traffic against a contact-level model.
module tb_ball_paddle_collide;
  localparam int HOLD = 16;
  localparam int BR = 10, PY = 700, PH = 10, PW = 128, SH = 768;
  logic        pclk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] ball_x = '0, ball_y = '0, pad_x = '0;
  logic        collision_det, miss;
  logic [7:0]  hit_count;
  int checks = 0, errors = 0;
  ball_paddle_collide #(.HOLD_MAX(HOLD)) dut (
    .pclk          (pclk),
    .reset         (reset),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .pad_x         (pad_x),
    .collision_det (collision_det),
    .miss          (miss),
    .hit_count     (hit_count)
  );
  always #5 pclk = ~pclk;
  // model: what the block has seen (positions one edge old), contact status and score
  int  x1, y1, p1, m_left, m_yhit, m_hits;
  bit  m_ov, m_active, m_lock, m_bot, m_miss;
  function automatic bit touches(int x, int y, int p);
    return (y + BR >= PY) && (y + BR <= PY + PH - 1) && (x + BR >= p) && (x <= p + PW - 1 + BR);
  endfunction
  task automatic mreset();
    x1 = 0; y1 = 0; p1 = 0; m_left = 0; m_yhit = 0; m_hits = 0;
    m_ov = 0; m_active = 0; m_lock = 0; m_bot = 0; m_miss = 0;
  endtask
  task automatic mstep();
    bit ov_new, b;
    ov_new = touches(x1, y1, p1);
    b = (y1 + BR >= SH - 1);
    m_miss = b && !m_bot;
    m_bot = b;
    if (m_active) begin
      if (y1 != m_yhit || m_left == 1) begin m_active = 0; m_lock = 1; end
      else m_left--;
    end else if (m_lock) begin
      if (!m_ov) m_lock = 0;
    end else if (m_ov) begin
      m_active = 1; m_left = HOLD; m_yhit = y1;
      if (m_hits < 255) m_hits++;
    end
    m_ov = ov_new; x1 = ball_x; y1 = ball_y; p1 = pad_x;
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic tick(int x, int y, int p);
    ball_x = 12'(x); ball_y = 12'(y); pad_x = 12'(p);
    @(posedge pclk);
    if (!reset) mreset(); else mstep();
    #1;
    chk("collision_det", collision_det, m_active);
    chk("miss", miss, m_miss);
    chk("hit_count", hit_count, m_hits);
  endtask
  typedef struct {int x; bit hit;} xv_t;
  xv_t xt[6];
  int n;
  initial begin
    xt[0] = '{340, 1'b1}; xt[1] = '{487, 1'b1}; xt[2] = '{339, 1'b0};
    xt[3] = '{488, 1'b0}; xt[4] = '{400, 1'b1}; xt[5] = '{200, 1'b0};
    mreset();
    // reset held with ball on the paddle
    for (int i = 0; i < 4; i++) tick(400, 690, 350);
    #2 reset = 1'b1;
    // nominal hit, consume, leave
    for (int i = 0; i < 3; i++) tick(400, 690, 350);
    chk("nominal_det", collision_det, 1);
    chk("nominal_count", hit_count, 1);
    tick(400, 689, 350);
    tick(400, 689, 350);
    chk("consumed_det", collision_det, 0);
    for (int i = 0; i < 4; i++) tick(400, 600, 350);
    chk("no_extra_count", hit_count, 1);
    // timeout: ball parked on the paddle
    reset = 1'b0; tick(400, 690, 350); #2 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(400, 690, 350); n += collision_det; end
    chk("timeout_len", n, HOLD);
    chk("timeout_det_low", collision_det, 0);
    chk("timeout_count", hit_count, 1);
    for (int i = 0; i < 4; i++) tick(400, 600, 350);
    for (int i = 0; i < 3; i++) tick(400, 690, 350);
    chk("reentry_count", hit_count, 2);
    // x boundaries
    foreach (xt[k]) begin
      for (int i = 0; i < 5; i++) tick(xt[k].x, 600, 350);
      for (int i = 0; i < 3; i++) tick(xt[k].x, 690, 350);
      chk("xbound", collision_det, xt[k].hit);
    end
    // miss approaching the bottom
    n = 0;
    for (int y = 750; y <= 757; y++) begin tick(100, y, 500); n += miss; end
    for (int i = 0; i < 5; i++) begin tick(100, 757, 500); n += miss; chk("miss_no_det", collision_det, 0); end
    chk("miss_pulses", n, 1);
    // saturation
    for (int h = 0; h < 260; h++) begin
      for (int i = 0; i < 3; i++) tick(400, 690, 350);
      for (int i = 0; i < 3; i++) tick(400, 600, 350);
    end
    chk("saturate", hit_count, 255);
    // asynchronous reset while asserting
    for (int i = 0; i < 3; i++) tick(400, 690, 350);
    chk("pre_reset_det", collision_det, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_det", collision_det, 0);
    chk("async_count", hit_count, 0);
    mreset();
    tick(400, 690, 350);
    #2 reset = 1'b1;
    // random traffic, including paddle near the top of the 12-bit range
    for (int i = 0; i < 3000; i++) begin
      int x, y, p, r;
      r = $urandom_range(0, 9);
      p = (r == 0) ? $urandom_range(3950, 4095) : $urandom_range(0, 900);
      x = (r == 1) ? $urandom_range(0, 4095) : p + $urandom_range(0, 160) - 15;
      if (x < 0) x = 0;
      if (x > 4095) x = 4095;
      y = (r < 3) ? $urandom_range(740, 770) : $urandom_range(684, 712);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) tick(x, y, p);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
